// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and counter sizing helper for the button debouncer.
package btn_pkg;

    typedef enum logic [2:0] {IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT} btn_state_t;

    // Width of one counter able to hold every terminal count; never below 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) {q_o, meta} <= 2'b00;
        else          {q_o, meta} <= {meta, d_i};

endmodule

// File: rtl/btn_debounce_repeat.sv
// btn_debounce_repeat: debounces an active-low button pin into a level plus press/release/auto-repeat pulses.
module btn_debounce_repeat
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_n_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);

    btn_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          btn_s, btn_nx, press_nx, release_nx, repeat_nx;

    sync_2ff u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (~btn_n_i),
        .q_o     (btn_s)
    );

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_o     <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            repeat_o  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            btn_o     <= btn_nx;
            press_o   <= press_nx;
            release_o <= release_nx;
            repeat_o  <= repeat_nx;
        end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:         if (btn_s) state_nx = PRESS_WAIT;
            PRESS_WAIT:   if (!btn_s) state_nx = IDLE;
                          else if (cnt == DB_LAST) state_nx = HELD;
            HELD:         if (!btn_s) state_nx = RELEASE_WAIT;
                          else if (cnt == HD_LAST) state_nx = REPEAT;
            REPEAT:       if (!btn_s) state_nx = RELEASE_WAIT;
            RELEASE_WAIT: if (btn_s) state_nx = HELD;
                          else if (cnt == DB_LAST) state_nx = IDLE;
            default:      state_nx = IDLE;
        endcase
        // Any state change restarts timing; the repeat period reloads in place.
        cnt_nx = (state_nx != state || state == IDLE || (state == REPEAT && cnt == RP_LAST))
                 ? '0 : cnt + CW'(1);
    end

    // Pulses are keyed to distinct source states, so at most one can fire per cycle.
    always_comb begin
        press_nx   = state == PRESS_WAIT && state_nx == HELD;
        release_nx = state == RELEASE_WAIT && state_nx == IDLE;
        repeat_nx  = (state == HELD && state_nx == REPEAT) ||
                     (state == REPEAT && btn_s && cnt == RP_LAST);
        btn_nx     = state_nx inside {HELD, REPEAT, RELEASE_WAIT};
    end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// tb_btn_debounce_repeat: scenario tasks with an event scoreboard for btn_debounce_repeat.
module tb_btn_debounce_repeat;

    typedef struct packed {
        logic [7:0]  k;
        logic [31:0] c;
    } ev_t;

    localparam logic [7:0] K_PR = 8'd0, K_RL = 8'd1, K_RP = 8'd2;

    logic clk = 1'b0, rst_n_i = 1'b0, btn_n_i = 1'b1;
    logic btn_o, press_o, release_o, repeat_o;
    int   cyc = 0, checks = 0, errors = 0, viol = 0, obs_rd = 0, t, u;
    logic last_press = 1'b0;
    logic [2:0] prev = 3'b000;
    ev_t  exp_q[$], obs_q[$], e;
    wire  [2:0] p = {press_o, release_o, repeat_o};

    btn_debounce_repeat #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .btn_n_i   (btn_n_i),
        .btn_o     (btn_o),
        .press_o   (press_o),
        .release_o (release_o),
        .repeat_o  (repeat_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every pulse with its cycle and tallies protocol violations.
    always @(negedge clk)
        if (!rst_n_i) begin
            prev       <= 3'b000;
            last_press <= 1'b0;
        end else begin
            if ($countones(p) > 1 || |(p & prev) || (press_o && last_press) ||
                (release_o && !last_press) || (repeat_o && !btn_o))
                viol <= viol + 1;
            if (press_o) last_press <= 1'b1;
            if (release_o) last_press <= 1'b0;
            prev <= p;
            if (p != 3'b000) obs_q.push_back('{press_o ? K_PR : release_o ? K_RL : K_RP, 32'(cyc)});
        end

    task automatic test_reset();
        #1;
        checks++;
        if ({btn_o, press_o, release_o, repeat_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async: got %b, want 0000", {btn_o, press_o, release_o, repeat_o});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({btn_o, press_o, release_o, repeat_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: got %b, want 0000", {btn_o, press_o, release_o, repeat_o});
        end
        rst_n_i = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({btn_o, press_o, release_o, repeat_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got %b, want 0000", {btn_o, press_o, release_o, repeat_o});
        end
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        btn_n_i = 1'b0;
        t = cyc;
        exp_q.push_back('{K_PR, 32'(t + 7)});
        exp_q.push_back('{K_RL, 32'(t + 15)});
        repeat (6) @(negedge clk);
        checks++;
        if ({btn_o, press_o} !== 2'b00) begin
            errors++;
            $display("FAIL press_early: got btn/press %b, want 00", {btn_o, press_o});
        end
        @(negedge clk);
        checks++;
        if ({btn_o, press_o} !== 2'b11) begin
            errors++;
            $display("FAIL press_edge: got btn/press %b, want 11", {btn_o, press_o});
        end
        @(negedge clk);
        btn_n_i = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (btn_o !== 1'b0) begin
            errors++;
            $display("FAIL clean_released: got btn_o %b, want 0", btn_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++;
                $display("FAIL clean_evt: got none, want k=%0d c=%0d", e.k, e.c);
            end else begin
                if (obs_q[obs_rd] !== e) begin
                    errors++;
                    $display("FAIL clean_evt: got k=%0d c=%0d, want k=%0d c=%0d",
                             obs_q[obs_rd].k, obs_q[obs_rd].c, e.k, e.c);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL clean_extra: got %0d events, want %0d", obs_q.size(), obs_rd);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_bounce();
        @(negedge clk);
        btn_n_i = 1'b0;
        repeat (2) @(negedge clk);
        btn_n_i = 1'b1;
        @(negedge clk);
        btn_n_i = 1'b0;
        repeat (2) @(negedge clk);
        btn_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (btn_o !== 1'b0) begin
                errors++;
                $display("FAIL bounce_level: got btn_o %b, want 0", btn_o);
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL bounce_extra: got %0d events, want %0d", obs_q.size(), obs_rd);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_auto_repeat();
        @(negedge clk);
        btn_n_i = 1'b0;
        t = cyc;
        exp_q.push_back('{K_PR, 32'(t + 7)});
        for (int j = 0; j < 9; j++) exp_q.push_back('{K_RP, 32'(t + 17 + 3 * j)});
        exp_q.push_back('{K_RL, 32'(t + 47)});
        repeat (40) @(negedge clk);
        checks++;
        if (btn_o !== 1'b1) begin
            errors++;
            $display("FAIL repeat_level: got btn_o %b, want 1", btn_o);
        end
        btn_n_i = 1'b1;
        repeat (15) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++;
                $display("FAIL repeat_evt: got none, want k=%0d c=%0d", e.k, e.c);
            end else begin
                if (obs_q[obs_rd] !== e) begin
                    errors++;
                    $display("FAIL repeat_evt: got k=%0d c=%0d, want k=%0d c=%0d",
                             obs_q[obs_rd].k, obs_q[obs_rd].c, e.k, e.c);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL repeat_extra: got %0d events, want %0d", obs_q.size(), obs_rd);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_release_bounce();
        @(negedge clk);
        btn_n_i = 1'b0;
        t = cyc;
        exp_q.push_back('{K_PR, 32'(t + 7)});
        exp_q.push_back('{K_RP, 32'(t + 27)});
        exp_q.push_back('{K_RP, 32'(t + 30)});
        exp_q.push_back('{K_RL, 32'(t + 37)});
        repeat (12) @(negedge clk);
        btn_n_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 1) btn_n_i = 1'b0;
            checks++;
            if (btn_o !== 1'b1) begin
                errors++;
                $display("FAIL relb_level: got btn_o %b, want 1 at cycle %0d", btn_o, cyc);
            end
            if (i == 17) btn_n_i = 1'b1;
        end
        repeat (12) @(negedge clk);
        checks++;
        if (btn_o !== 1'b0) begin
            errors++;
            $display("FAIL relb_released: got btn_o %b, want 0", btn_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++;
                $display("FAIL relb_evt: got none, want k=%0d c=%0d", e.k, e.c);
            end else begin
                if (obs_q[obs_rd] !== e) begin
                    errors++;
                    $display("FAIL relb_evt: got k=%0d c=%0d, want k=%0d c=%0d",
                             obs_q[obs_rd].k, obs_q[obs_rd].c, e.k, e.c);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL relb_extra: got %0d events, want %0d", obs_q.size(), obs_rd);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_reset_mid_press();
        @(negedge clk);
        btn_n_i = 1'b0;
        t = cyc;
        exp_q.push_back('{K_PR, 32'(t + 7)});
        exp_q.push_back('{K_RP, 32'(t + 17)});
        repeat (19) @(negedge clk);
        checks++;
        if (btn_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got btn_o %b, want 1", btn_o);
        end
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({btn_o, press_o, release_o, repeat_o} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async: got %b, want 0000", {btn_o, press_o, release_o, repeat_o});
        end
        @(negedge clk);
        checks++;
        if ({btn_o, press_o, release_o, repeat_o} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_held: got %b, want 0000", {btn_o, press_o, release_o, repeat_o});
        end
        @(negedge clk);
        rst_n_i = 1'b1;
        u = cyc;
        exp_q.push_back('{K_PR, 32'(u + 7)});
        exp_q.push_back('{K_RL, 32'(u + 17)});
        repeat (10) @(negedge clk);
        btn_n_i = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (btn_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_released: got btn_o %b, want 0", btn_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++;
                $display("FAIL rst_evt: got none, want k=%0d c=%0d", e.k, e.c);
            end else begin
                if (obs_q[obs_rd] !== e) begin
                    errors++;
                    $display("FAIL rst_evt: got k=%0d c=%0d, want k=%0d c=%0d",
                             obs_q[obs_rd].k, obs_q[obs_rd].c, e.k, e.c);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            errors++;
            $display("FAIL rst_extra: got %0d events, want %0d", obs_q.size(), obs_rd);
        end
        obs_rd = obs_q.size();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL protocol: got %0d violations, want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_bounce();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
